// File: rtl/riscv_core_icache_ctrl.sv
// Instruction cache controller: tag/valid array, hit detection for one or two
// 32-byte blocks per fetch, and a single-beat AXI refill FSM that drives the
// data memory control pins.
`timescale 1ns/1ps
module riscv_core_icache_ctrl #(
  parameter int BLOCK_OFFSET_WIDTH = 3,
  parameter int INDEX_WIDTH        = 7,
  parameter int ADDR_WIDTH         = 64,
  parameter int TAG_WIDTH          = ADDR_WIDTH - INDEX_WIDTH - BLOCK_OFFSET_WIDTH - 2
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_req_valid,
  input  logic [ADDR_WIDTH-1:0] i_req_addr,
  output logic                  o_req_ready,
  output logic                  o_rsp_valid,
  output logic                  o_rsp_err,
  input  logic                  i_flush,
  output logic                  o_mem_rd_en,
  output logic                  o_mem_wr_en,
  output logic                  o_mem_block_replace,
  output logic                  o_mem_offset,
  output logic                  o_axi_arvalid,
  output logic [ADDR_WIDTH-1:0] o_axi_araddr,
  input  logic                  i_axi_arready,
  input  logic                  i_axi_rvalid,
  input  logic [1:0]            i_axi_rresp,
  output logic                  o_axi_rready,
  output logic                  o_busy
);

  localparam int SETS   = 1 << INDEX_WIDTH;
  localparam int IDX_LO = BLOCK_OFFSET_WIDTH + 2;
  localparam int IDX_HI = INDEX_WIDTH + BLOCK_OFFSET_WIDTH + 1;
  localparam int TAG_LO = IDX_HI + 1;

  typedef enum logic [1:0] {S_IDLE, S_AR, S_R, S_ERR} state_e;

  state_e                 state_q, state_d;
  logic                   sel_q, sel_d;
  logic                   flush_pend_q, flush_pend_d;
  logic [SETS-1:0]        vld_q, vld_d;
  logic [TAG_WIDTH-1:0]   tag_q [SETS];

  logic [ADDR_WIDTH-1:0]  addr_b, sel_addr;
  logic [INDEX_WIDTH-1:0] idx_a, idx_b, sel_idx;
  logic [TAG_WIDTH-1:0]   tag_a, tag_b, sel_tag;
  logic                   hit_a, hit_b, need_b, hit, fill, flush_now;

  // Address decomposition and combinational lookup of both candidate blocks
  always_comb begin
    addr_b   = i_req_addr + ADDR_WIDTH'(2);
    idx_a    = i_req_addr[IDX_HI:IDX_LO];
    idx_b    = addr_b[IDX_HI:IDX_LO];
    tag_a    = i_req_addr[ADDR_WIDTH-1:TAG_LO];
    tag_b    = addr_b[ADDR_WIDTH-1:TAG_LO];
    hit_a    = vld_q[idx_a] && (tag_q[idx_a] == tag_a);
    hit_b    = vld_q[idx_b] && (tag_q[idx_b] == tag_b);
    need_b   = (idx_a != idx_b) || (tag_a != tag_b);
    hit      = hit_a && (!need_b || hit_b);
    sel_addr = sel_q ? addr_b : i_req_addr;
    sel_idx  = sel_addr[IDX_HI:IDX_LO];
    sel_tag  = sel_addr[ADDR_WIDTH-1:TAG_LO];
    fill     = (state_q == S_R) && i_axi_rvalid && (i_axi_rresp == 2'b00);
  end

  // Next-state logic of the refill FSM
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    case (state_q)
      S_IDLE: begin
        if (i_req_valid && !hit) begin
          sel_d   = hit_a;
          state_d = S_AR;
        end
      end
      S_AR: begin
        if (i_axi_arready) state_d = S_R;
      end
      S_R: begin
        if (i_axi_rvalid) begin
          if (i_axi_rresp != 2'b00) begin
            state_d = S_ERR;
          end else if (!sel_q && need_b && !hit_b) begin
            sel_d   = 1'b1;
            state_d = S_AR;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Valid bits and deferred flush; a pending flush wins over a same-edge fill
  always_comb begin
    flush_now = (state_q == S_IDLE && i_flush) ||
                (state_q != S_IDLE && state_d == S_IDLE && (flush_pend_q || i_flush));
    vld_d        = vld_q;
    flush_pend_d = flush_pend_q;
    if (fill) vld_d[sel_idx] = 1'b1;
    if (state_q != S_IDLE && i_flush) flush_pend_d = 1'b1;
    if (flush_now) begin
      vld_d        = '0;
      flush_pend_d = 1'b0;
    end
  end

  // State, selector, flush-pending and valid registers
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q      <= S_IDLE;
      sel_q        <= 1'b0;
      flush_pend_q <= 1'b0;
      vld_q        <= '0;
    end else begin
      state_q      <= state_d;
      sel_q        <= sel_d;
      flush_pend_q <= flush_pend_d;
      vld_q        <= vld_d;
    end
  end

  // Tag array; contents are meaningless while the matching valid bit is clear
  always_ff @(posedge i_clk) begin
    if (fill) tag_q[sel_idx] <= sel_tag;
  end

  // Output decode per state
  always_comb begin
    o_req_ready         = 1'b0;
    o_rsp_valid         = 1'b0;
    o_rsp_err           = 1'b0;
    o_mem_rd_en         = 1'b0;
    o_mem_wr_en         = 1'b0;
    o_mem_block_replace = 1'b0;
    o_mem_offset        = 1'b0;
    o_axi_arvalid       = 1'b0;
    o_axi_araddr        = '0;
    o_axi_rready        = 1'b0;
    o_busy              = (state_q != S_IDLE);
    case (state_q)
      S_IDLE: begin
        if (i_req_valid && hit) begin
          o_mem_rd_en = 1'b1;
          o_rsp_valid = 1'b1;
          o_req_ready = 1'b1;
        end
      end
      S_AR: begin
        o_axi_arvalid             = 1'b1;
        o_axi_araddr              = sel_addr;
        o_axi_araddr[IDX_LO-1:0]  = '0;
      end
      S_R: begin
        o_axi_rready = 1'b1;
        if (fill) begin
          o_mem_wr_en         = 1'b1;
          o_mem_block_replace = 1'b1;
          o_mem_offset        = sel_q;
        end
      end
      default: begin
        o_rsp_valid = 1'b1;
        o_rsp_err   = 1'b1;
        o_req_ready = 1'b1;
      end
    endcase
  end

endmodule

// File: tb/tb_riscv_core_icache_ctrl.sv
// Directed bench for riscv_core_icache_ctrl: a transaction-level cache model
// expands each fetch into the expected per-cycle output timeline, and one
// compare process checks every cycle against it.
`timescale 1ns/1ps
module tb_riscv_core_icache_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic [63:0] req_addr = '0;
  logic        flush = 1'b0;
  logic        axi_arready = 1'b0;
  logic        axi_rvalid = 1'b0;
  logic [1:0]  axi_rresp = 2'b00;
  logic        req_ready, rsp_valid, rsp_err, mem_rd_en, mem_wr_en;
  logic        mem_block_replace, mem_offset, axi_arvalid, axi_rready, busy;
  logic [63:0] axi_araddr;

  always #5 clk = ~clk;

  riscv_core_icache_ctrl #(
    .BLOCK_OFFSET_WIDTH(3),
    .INDEX_WIDTH(7),
    .ADDR_WIDTH(64),
    .TAG_WIDTH(52)
  ) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_req_valid(req_valid), .i_req_addr(req_addr),
    .o_req_ready(req_ready), .o_rsp_valid(rsp_valid), .o_rsp_err(rsp_err),
    .i_flush(flush),
    .o_mem_rd_en(mem_rd_en), .o_mem_wr_en(mem_wr_en),
    .o_mem_block_replace(mem_block_replace), .o_mem_offset(mem_offset),
    .o_axi_arvalid(axi_arvalid), .o_axi_araddr(axi_araddr),
    .i_axi_arready(axi_arready), .i_axi_rvalid(axi_rvalid), .i_axi_rresp(axi_rresp),
    .o_axi_rready(axi_rready), .o_busy(busy)
  );

  typedef struct packed {
    logic        ready, rsp, err, rd, wr, repl, off, arv;
    logic [63:0] araddr;
    logic        rready, busy;
  } obs_t;

  obs_t        exp_q[$];
  int          checks = 0;
  int          errors = 0;
  bit          mvalid [128];
  logic [51:0] mtag   [128];
  int          ar_delay = 0;
  int          ar_cnt = 0;
  logic [1:0]  bus_resp = 2'b00;
  int          len;

  // ---------------- cache model ----------------
  function automatic logic [6:0] m_idx(input logic [63:0] a);
    return a[11:5];
  endfunction
  function automatic logic [51:0] m_tag(input logic [63:0] a);
    return a[63:12];
  endfunction
  function automatic logic [63:0] m_blk(input logic [63:0] a);
    return (a >> 5) << 5;
  endfunction
  function automatic bit m_need_b(input logic [63:0] a);
    return (a >> 5) != ((a + 64'd2) >> 5);
  endfunction
  function automatic bit m_hit(input logic [63:0] a);
    return mvalid[m_idx(a)] && (mtag[m_idx(a)] == m_tag(a));
  endfunction
  function automatic void m_clear();
    for (int i = 0; i < 128; i++) mvalid[i] = 1'b0;
  endfunction
  function automatic void m_fill(input logic [63:0] a);
    mvalid[m_idx(a)] = 1'b1;
    mtag[m_idx(a)]   = m_tag(a);
  endfunction

  function automatic obs_t o_hit();
    obs_t o = '0; o.ready = 1; o.rsp = 1; o.rd = 1; return o;
  endfunction
  function automatic obs_t o_ar(input logic [63:0] a);
    obs_t o = '0; o.arv = 1; o.araddr = a; o.busy = 1; return o;
  endfunction
  function automatic obs_t o_r(input bit ok, input bit off);
    obs_t o = '0; o.rready = 1; o.busy = 1;
    if (ok) begin o.wr = 1; o.repl = 1; o.off = off; end
    return o;
  endfunction
  function automatic obs_t o_errst();
    obs_t o = '0; o.ready = 1; o.rsp = 1; o.err = 1; o.busy = 1; return o;
  endfunction

  // Expand one fetch into its cycle-by-cycle expected outputs, updating the model
  function automatic void build(input logic [63:0] a, input int flush_at, input logic [1:0] resp);
    int n = 0;
    bit pend;
    bit sel;
    logic [63:0] b, blk;
    b = a + 64'd2;
    while (1) begin
      if (m_hit(a) && (!m_need_b(a) || m_hit(b))) begin
        exp_q.push_back(o_hit());
        if (flush_at == n) m_clear();
        return;
      end
      exp_q.push_back('0);
      if (flush_at == n) m_clear();
      n++;
      pend = 0;
      sel  = m_hit(a);
      while (1) begin
        blk = sel ? b : a;
        for (int d = 0; d <= ar_delay; d++) begin
          exp_q.push_back(o_ar(m_blk(blk)));
          if (flush_at == n) pend = 1;
          n++;
        end
        if (resp != 2'b00) begin
          exp_q.push_back(o_r(0, 0));
          if (flush_at == n) pend = 1;
          n++;
          exp_q.push_back(o_errst());
          if (flush_at == n) pend = 1;
          if (pend) m_clear();
          return;
        end
        exp_q.push_back(o_r(1, sel));
        if (flush_at == n) pend = 1;
        n++;
        m_fill(blk);
        if (!sel && m_need_b(a) && !m_hit(b)) sel = 1;
        else break;
      end
      if (pend) m_clear();
    end
  endfunction

  // ---------------- checking ----------------
  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, got, exp);
    end
  endtask

  // Single per-cycle compare of all outputs against the expected timeline
  always @(negedge clk) begin
    obs_t got, exp;
    got = {req_ready, rsp_valid, rsp_err, mem_rd_en, mem_wr_en, mem_block_replace,
           mem_offset, axi_arvalid, axi_araddr, axi_rready, busy};
    exp = (exp_q.size() > 0) ? exp_q.pop_front() : obs_t'('0);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL outputs @%0t addr=%h: got rdy=%b rsp=%b err=%b rd=%b wr=%b rep=%b off=%b arv=%b ara=%h rrdy=%b busy=%b; required rdy=%b rsp=%b err=%b rd=%b wr=%b rep=%b off=%b arv=%b ara=%h rrdy=%b busy=%b",
               $time, req_addr, got.ready, got.rsp, got.err, got.rd, got.wr, got.repl, got.off,
               got.arv, got.araddr, got.rready, got.busy, exp.ready, exp.rsp, exp.err, exp.rd,
               exp.wr, exp.repl, exp.off, exp.arv, exp.araddr, exp.rready, exp.busy);
    end
  end

  // AXI slave: arready after ar_delay cycles of arvalid, R beat as soon as rready
  always @(posedge clk) begin
    #1;
    if (axi_arvalid) begin
      axi_arready = (ar_cnt >= ar_delay);
      ar_cnt++;
    end else begin
      axi_arready = 1'b0;
      ar_cnt = 0;
    end
    axi_rvalid = axi_rready;
    axi_rresp  = axi_rready ? bus_resp : 2'b00;
  end

  // ---------------- stimulus ----------------
  task automatic fetch(input logic [63:0] a, input int flush_at, input logic [1:0] resp,
                       input int ard, output int n);
    ar_delay = ard;
    bus_resp = resp;
    build(a, flush_at, resp);
    n = exp_q.size();
    req_valid = 1'b1;
    req_addr  = a;
    flush     = (flush_at == 0);
    for (int c = 1; c <= n; c++) begin
      @(posedge clk); #1;
      if (c < n) flush = (flush_at == c);
    end
    req_valid = 1'b0;
    flush     = 1'b0;
  endtask

  task automatic idle_flush();
    exp_q.push_back('0);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    m_clear();
  endtask

  initial begin
    m_clear();
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    // Model pins: field arithmetic on hand-picked addresses
    chk("need_b_straddle", 64'(m_need_b(64'h101E)), 64'd1);
    chk("need_b_inside",   64'(m_need_b(64'h101C)), 64'd0);
    chk("idx_alias_2000",  64'(m_idx(64'h2000)),    64'd0);
    chk("idx_wrap_1ffe",   64'(m_idx(64'h1FFE)),    64'd127);
    chk("blk_of_b",        m_blk(64'h101E + 64'd2), 64'h1020);

    // Cold miss then same-block hit
    fetch(64'h1000, -1, 2'b00, 0, len); chk("t1_miss_cycles", 64'(len), 64'd4);
    fetch(64'h1004, -1, 2'b00, 0, len); chk("t1_hit_cycles",  64'(len), 64'd1);
    // A resident, only B refilled
    fetch(64'h101E, -1, 2'b00, 0, len); chk("t3_b_only",      64'(len), 64'd4);
    // Flush in IDLE then miss again
    idle_flush();
    fetch(64'h1000, -1, 2'b00, 0, len); chk("t5_after_flush", 64'(len), 64'd4);
    // Straddle with both blocks cold
    idle_flush();
    fetch(64'h101E, -1, 2'b00, 0, len); chk("t2_two_blocks",  64'(len), 64'd6);
    // Bus error, then retry
    fetch(64'h2000, -1, 2'b10, 0, len); chk("t4_err_cycles",  64'(len), 64'd4);
    fetch(64'h2000, -1, 2'b00, 0, len); chk("t4_retry",       64'(len), 64'd4);
    // Alias evicts 0x2000
    fetch(64'h1000, -1, 2'b00, 0, len); chk("t6_alias",       64'(len), 64'd4);
    // Flush during AR (deferred) and during R
    fetch(64'h4000, 1, 2'b00, 0, len);  chk("t5_flush_ar",    64'(len), 64'd7);
    fetch(64'h4040, 2, 2'b00, 0, len);  chk("t5_flush_r",     64'(len), 64'd7);
    fetch(64'h1020, -1, 2'b00, 0, len); chk("t5_flushed_blk", 64'(len), 64'd4);
    // arready stall holds address
    fetch(64'h5000, -1, 2'b00, 2, len); chk("ar_stall",       64'(len), 64'd6);
    // Straddle across the last set into set 0
    fetch(64'h1FFE, -1, 2'b00, 0, len); chk("wrap_straddle",  64'(len), 64'd6);

    // Reset while in R
    ar_delay = 0; bus_resp = 2'b00;
    exp_q.push_back('0);
    exp_q.push_back(o_ar(64'h3000));
    req_valid = 1'b1; req_addr = 64'h3000;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("pre_rst_rready", 64'(axi_rready), 64'd1);
    rst_n = 1'b0; req_valid = 1'b0;
    m_clear();
    #1;
    chk("rst_busy",   64'(busy), 64'd0);
    chk("rst_rready", 64'(axi_rready), 64'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    fetch(64'h1000, -1, 2'b00, 0, len); chk("post_rst_miss", 64'(len), 64'd4);

    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
